serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial ripple adder built around the existing single-bit full adder (`full_adder_bh`).
- Loads two WIDTH-bit operands plus carry-in on a start pulse, then adds one bit per clock, LSB first.
- The carry is held in a flip-flop between bits.
- Sits downstream of the full adder: it consumes that adder's s/c outputs each cycle and trades area for latency versus a combinational ripple-carry adder.

Parameters:
- WIDTH, 8, operand and sum width in bits. Legal range is 2..32.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  synchronous active-low reset
- start  input  1  request to begin an addition; sampled only while idle
- a  input  WIDTH  operand A, captured on an accepted start
- b  input  WIDTH  operand B, captured on an accepted start
- cin  input  1  carry-in, captured on an accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when sum/cout become valid
- sum  output  WIDTH  registered result, a+b+cin mod 2^WIDTH
- cout  output  1  registered carry-out of the MSB

Behaviour:
- Clock and reset are fixed: one clock (clk); reset is synchronous and active-low (rst_n).
  - Reset is sampled only on the rising clk edge.
- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE.
  - The internal shift registers, carry flip-flop and bit counter also clear to 0.
- States:
  - IDLE: waiting.
  - RUN: shifting.
- IDLE:
  - If start=1 at an edge: capture a→a_sh, b→b_sh, cin→carry, set cnt=0, busy=1, go to RUN.
  - Otherwise hold.
- RUN, at each edge:
  - The full adder sees (a_sh[0], b_sh[0], carry).
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}.
  - carry <= c.
  - a_sh and b_sh shift right by one with zero fill.
  - cnt increments.
- Completion (RUN edge with cnt==WIDTH-1):
  - The final bit is processed.
  - sum <= {s, sum_sh[WIDTH-1:1]}, cout <= c.
  - done <= 1, busy <= 0, state goes to IDLE.
- Latency:
  - start is accepted at edge E0.
  - sum, cout and done update at edge E0+WIDTH.
  - done is high for exactly one cycle.
- done and start coincide:
  - start=1 in the cycle where done=1 is accepted, because the block is already IDLE.
  - This allows back-to-back additions with a WIDTH+1 clock period.
- start while busy=1 is ignored, with no effect on operands or progress.
- sum and cout hold their last result until the next completion; they never show partial values.
- done is not re-asserted while idle.
- Reset mid-operation:
  - Aborts at that edge.
  - All outputs return to reset values.
  - The partial result is discarded.
- a, b and cin may change freely after acceptance; only the captured copies are used.
- Width rule: result = (a + b + cin) taken to WIDTH+1 bits, with cout as the MSB. There is no overflow flag.
- cnt width is $clog2(WIDTH), minimum 1 bit. cnt must not wrap before completion.

Decomposition:
- No shared package is needed.
  - State encodings (IDLE=1'b0, RUN=1'b1) are localparams inside the module.
- One sub-module instance: `full_adder_bh` (port order s, c, a, b, cin), reused unmodified from the combinational library.
- The bench includes both source files.

Test Plan (WIDTH=4 unless noted):
- Basic add: a=3, b=5, cin=0, start pulse → at edge E0+4: sum=8, cout=0, done=1 for one cycle; busy high for edges E0+1..E0+4.
- Carry-out and wrap: a=15, b=1, cin=0 → sum=0, cout=1. Then a=15, b=15, cin=1 → sum=15, cout=1.
- Start while busy: start a=1, b=1. At E0+2 pulse start with a=7, b=7 → that start is ignored; result sum=2, cout=0 at E0+4; only one done pulse.
- Back-to-back: assert start with a=2, b=9, cin=1 in the done cycle of a previous add → accepted; sum=12, cout=0 after 4 more edges; the earlier result holds until then.
- Reset mid-operation: rst_n=0 at E0+2 → at that edge busy=0, done=0, sum=0, cout=0. A subsequent start with a=6, b=6 completes correctly: sum=12, cout=0.
- Exhaustive sweep: all 512 combinations of a, b, cin with WIDTH=4; also random vectors with WIDTH=8 → {cout,sum} equals a+b+cin for every case, and done arrives exactly WIDTH edges after acceptance.

Source files
------------

// File: rtl/full_adder_bh.sv
// Single-bit full adder from the combinational library, described behaviourally.
// The serial adder instantiates it once and feeds it one operand bit per clock.
module full_adder_bh (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder plus shift registers, LSB first.
// A new result appears WIDTH clocks after start is accepted, with cout as bit WIDTH.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_c;

    full_adder_bh u_fa (
        .s   (fa_s),
        .c   (fa_c),
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry)
    );

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST_BIT) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values, so the
    // shift, carry and counter updates below are order-independent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                    carry  <= fa_c;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + 1'b1;
                    // The final bit goes straight into the visible result, so sum never shows partials.
                    if (cnt == LAST_BIT) begin
                        sum  <= {fa_s, sum_sh[WIDTH-1:1]};
                        cout <= fa_c;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
